// File: rtl/hybrid_control_pipelined.sv
// Pipelined theta/phi hybrid controller: 3-stage half-plane evaluation, debounced conditions, 4-state sigma automaton.
// Optional turn-on deadtime on o_MOSFET is enabled by defining DEADTIME_EN.
module hybrid_control_pipelined #(
  parameter int W_IN      = 14,
  parameter int W_TRIG    = 16,
  parameter int W_ACC     = 64,
  parameter int MU_Z1     = 86,
  parameter int MU_Z2     = 90,
  parameter int MU_VG     = 312000,
  parameter int DEBOUNCE  = 2,
  parameter int MIN_DWELL = 20,
  parameter int DEADTIME  = 8
) (
  input  logic                     i_clock,
  input  logic                     i_RESET,
  input  logic                     i_enable,
  input  logic                     i_mode,
  input  logic signed [W_IN-1:0]   i_vC,
  input  logic signed [W_IN-1:0]   i_iC,
  input  logic signed [W_TRIG-1:0] i_stpf,
  input  logic signed [W_TRIG-1:0] i_ctpf,
  input  logic signed [W_TRIG-1:0] i_stmf,
  input  logic signed [W_TRIG-1:0] i_ctmf,
  output logic [3:0]               o_MOSFET,
  output logic [1:0]               o_sigma,
  output logic [1:0]               o_state,
  output logic                     o_jump,
  output logic [3:0]               o_cond
);

  typedef enum logic [1:0] {ST_P = 2'b00, ST_Z1 = 2'b01, ST_N = 2'b10, ST_Z2 = 2'b11} state_t;

  localparam int DWELL_CYC = (MIN_DWELL < 3) ? 3 : MIN_DWELL;
  localparam int DWELL_W   = $clog2(DWELL_CYC + 1);
  localparam int DB_W      = $clog2(DEBOUNCE + 1);
  localparam logic signed [W_ACC-1:0] K_Z1 = W_ACC'(MU_Z1);
  localparam logic signed [W_ACC-1:0] K_Z2 = W_ACC'(MU_Z2);
  localparam logic signed [W_ACC-1:0] K_VG = W_ACC'(MU_VG);

  state_t               state_reg, state_next;
  logic [DWELL_W-1:0]   dwell_reg, dwell_next;
  logic                 jump_reg, jump_next;
  logic [3:0]           mosfet_reg, mosfet_next;
  logic [1:0]           sigma_dec;
  logic [3:0]           cond_raw, cond_q;
  logic signed [W_ACC-1:0] vg_term;

  logic signed [W_ACC-1:0]  z1_s1_reg, z2_s1_reg, c_s1_reg;
  logic signed [W_TRIG-1:0] stpf_s1_reg, ctpf_s1_reg, stmf_s1_reg, ctmf_s1_reg;
  logic signed [W_ACC-1:0]  pa_s2_reg, pb_s2_reg, pc_s2_reg, pd_s2_reg, c_s2_reg;
  logic signed [W_ACC-1:0]  s1_s3_reg, s2_s3_reg, s3_s3_reg;

  // sigma*MU_VG feedback uses the state that is current when the sample enters the pipe
  always_comb begin
    vg_term = '0;
    case (state_reg)
      ST_P:    vg_term = K_VG;
      ST_N:    vg_term = -K_VG;
      default: vg_term = '0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      z1_s1_reg   <= '0;
      z2_s1_reg   <= '0;
      c_s1_reg    <= '0;
      stpf_s1_reg <= '0;
      ctpf_s1_reg <= '0;
      stmf_s1_reg <= '0;
      ctmf_s1_reg <= '0;
      pa_s2_reg   <= '0;
      pb_s2_reg   <= '0;
      pc_s2_reg   <= '0;
      pd_s2_reg   <= '0;
      c_s2_reg    <= '0;
      s1_s3_reg   <= '0;
      s2_s3_reg   <= '0;
      s3_s3_reg   <= '0;
    end else begin
      z1_s1_reg   <= K_Z1 * W_ACC'(i_vC) - vg_term;
      z2_s1_reg   <= K_Z2 * W_ACC'(i_iC);
      c_s1_reg    <= K_VG * W_ACC'(i_stmf);
      stpf_s1_reg <= i_stpf;
      ctpf_s1_reg <= i_ctpf;
      stmf_s1_reg <= i_stmf;
      ctmf_s1_reg <= i_ctmf;
      pa_s2_reg   <= z1_s1_reg * W_ACC'(stmf_s1_reg);
      pb_s2_reg   <= z2_s1_reg * W_ACC'(ctmf_s1_reg);
      pc_s2_reg   <= z1_s1_reg * W_ACC'(stpf_s1_reg);
      pd_s2_reg   <= z2_s1_reg * W_ACC'(ctpf_s1_reg);
      c_s2_reg    <= c_s1_reg;
      s1_s3_reg   <= pa_s2_reg + pb_s2_reg + c_s2_reg;
      s2_s3_reg   <= pc_s2_reg + pd_s2_reg;
      s3_s3_reg   <= pa_s2_reg + pb_s2_reg - c_s2_reg;
    end
  end

  assign cond_raw[0] = ~s1_s3_reg[W_ACC-1];
  assign cond_raw[1] = ~s2_s3_reg[W_ACC-1];
  assign cond_raw[2] =  s3_s3_reg[W_ACC-1];
  assign cond_raw[3] =  s2_s3_reg[W_ACC-1];

  // Flag rises on the DEBOUNCE-th consecutive raw-true cycle, drops on the first raw-false one
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_reg;
      logic            flag_reg;
      always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
          cnt_reg  <= '0;
          flag_reg <= 1'b0;
        end else if (cond_raw[gi]) begin
          if (cnt_reg != DB_W'(DEBOUNCE)) cnt_reg <= cnt_reg + 1'b1;
          flag_reg <= (cnt_reg >= DB_W'(DEBOUNCE - 1));
        end else begin
          cnt_reg  <= '0;
          flag_reg <= 1'b0;
        end
      end
      assign cond_q[gi] = flag_reg;
    end
  endgenerate

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_reg  <= ST_P;
      dwell_reg  <= '0;
      jump_reg   <= 1'b0;
      mosfet_reg <= '0;
    end else begin
      state_reg  <= state_next;
      dwell_reg  <= dwell_next;
      jump_reg   <= jump_next;
      mosfet_reg <= mosfet_next;
    end
  end

  always_comb begin
    jump_next  = i_enable && cond_q[state_reg] && (dwell_reg == '0);
    state_next = state_reg;
    dwell_next = dwell_reg;
    if (!i_enable) begin
      state_next = ST_P;
      dwell_next = '0;
    end else if (jump_next) begin
      dwell_next = DWELL_W'(DWELL_CYC);
      if (i_mode) state_next = state_t'(state_reg + 2'd1);
      else        state_next = state_reg[1] ? ST_P : ST_N;
    end else if (dwell_reg != '0) begin
      dwell_next = dwell_reg - 1'b1;
    end
  end

  always_comb begin
    sigma_dec   = 2'b00;
    mosfet_next = 4'b0011;
    case (state_reg)
      ST_P:    begin sigma_dec = 2'b01; mosfet_next = 4'b1001; end
      ST_N:    begin sigma_dec = 2'b11; mosfet_next = 4'b0110; end
      default: begin sigma_dec = 2'b00; mosfet_next = 4'b0011; end
    endcase
    if (!i_enable) mosfet_next = 4'b0000;
  end

`ifdef DEADTIME_EN
  localparam int DT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  logic [DT_W-1:0] dt_cnt_reg;
  logic [3:0]      gate_reg;

  // Turn-off passes at once; turn-on waits out the timer, restarted on every new target
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      dt_cnt_reg <= '0;
      gate_reg   <= '0;
    end else if (mosfet_next != mosfet_reg) begin
      if (DEADTIME == 0) begin
        gate_reg <= mosfet_next;
      end else begin
        gate_reg   <= gate_reg & mosfet_next;
        dt_cnt_reg <= DT_W'(DEADTIME);
      end
    end else if (dt_cnt_reg == DT_W'(1)) begin
      gate_reg   <= mosfet_reg;
      dt_cnt_reg <= '0;
    end else if (dt_cnt_reg != '0) begin
      dt_cnt_reg <= dt_cnt_reg - 1'b1;
    end
  end
  assign o_MOSFET = gate_reg;
`else
  assign o_MOSFET = mosfet_reg;
`endif

  assign o_sigma = sigma_dec;
  assign o_state = state_reg;
  assign o_jump  = jump_reg;
  assign o_cond  = cond_q;

endmodule

// File: tb/tb_hybrid_control_pipelined.sv
// Directed bench for hybrid_control_pipelined (default parameters, DEADTIME_EN undefined).
module tb_hybrid_control_pipelined;

  logic                i_clock = 1'b0;
  logic                i_RESET = 1'b0;
  logic                i_enable = 1'b1;
  logic                i_mode = 1'b1;
  logic signed [13:0]  i_vC = '0;
  logic signed [13:0]  i_iC = '0;
  logic signed [15:0]  i_stpf = '0;
  logic signed [15:0]  i_ctpf = '0;
  logic signed [15:0]  i_stmf = '0;
  logic signed [15:0]  i_ctmf = '0;
  logic [3:0]          o_MOSFET;
  logic [1:0]          o_sigma;
  logic [1:0]          o_state;
  logic                o_jump;
  logic [3:0]          o_cond;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 i_clock = ~i_clock;

  hybrid_control_pipelined dut (
    .i_clock  (i_clock),
    .i_RESET  (i_RESET),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .i_vC     (i_vC),
    .i_iC     (i_iC),
    .i_stpf   (i_stpf),
    .i_ctpf   (i_ctpf),
    .i_stmf   (i_stmf),
    .i_ctmf   (i_ctmf),
    .o_MOSFET (o_MOSFET),
    .o_sigma  (o_sigma),
    .o_state  (o_state),
    .o_jump   (o_jump),
    .o_cond   (o_cond)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("check %s: %0h ok", tag, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic wait_jump(input string tag, input int limit);
    int n;
    n = 0;
    while (!o_jump && n < limit) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'd0, o_jump}, 32'd1);
  endtask

  logic bad;

  initial begin
    // Reset with enable high and all inputs zero
    tick(3);
    check_eq("rst_sigma",  {30'd0, o_sigma}, 32'h1);
    check_eq("rst_mosfet", {28'd0, o_MOSFET}, 32'h0);
    check_eq("rst_state",  {30'd0, o_state}, 32'h0);
    check_eq("rst_jump",   {31'd0, o_jump}, 32'h0);
    check_eq("rst_cond",   {28'd0, o_cond}, 32'h0);
    i_RESET = 1'b1;
    tick(1);
    check_eq("rel_mosfet", {28'd0, o_MOSFET}, 32'h9);
    check_eq("rel_state",  {30'd0, o_state}, 32'h0);

    // Park disabled while the pipeline fills; C1 false in P (S1 = -90)
    i_enable = 1'b0;
    i_iC = -14'sd1;
    i_ctmf = 16'sd1;
    tick(10);
    $display("txn park: cond=%b state=%b", o_cond, o_state);
    check_eq("park_cond",   {28'd0, o_cond}, 32'h6);
    check_eq("park_mosfet", {28'd0, o_MOSFET}, 32'h0);

    // Mode 1: enable, then present stmf=16384 so that S1 = 0
    i_enable = 1'b1;
    tick(5);
    check_eq("idle_state", {30'd0, o_state}, 32'h0);
    i_iC = '0;
    i_ctmf = '0;
    i_stmf = 16'sd16384;
    tick(4);
    check_eq("deb_mid_c1", {31'd0, o_cond[0]}, 32'h0);
    tick(1);
    check_eq("deb_set_c1", {31'd0, o_cond[0]}, 32'h1);
    check_eq("pre_jump_state", {30'd0, o_state}, 32'h0);
    tick(1);
    $display("txn jump1: state=%b sigma=%b jump=%b", o_state, o_sigma, o_jump);
    check_eq("j1_state", {30'd0, o_state}, 32'h1);
    check_eq("j1_sigma", {30'd0, o_sigma}, 32'h0);
    check_eq("j1_jump",  {31'd0, o_jump}, 32'h1);
    tick(1);
    check_eq("j1_pulse_end", {31'd0, o_jump}, 32'h0);
    check_eq("j1_mosfet", {28'd0, o_MOSFET}, 32'h3);
    bad = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      tick(1);
      bad = bad | o_jump | (o_state != 2'b01);
    end
    check_eq("dwell_block", {31'd0, bad}, 32'h0);
    tick(1);
    $display("txn jump2: state=%b jump=%b", o_state, o_jump);
    check_eq("j2_state", {30'd0, o_state}, 32'h2);
    check_eq("j2_jump",  {31'd0, o_jump}, 32'h1);
    tick(30);
    check_eq("n_state",  {30'd0, o_state}, 32'h2);
    check_eq("n_sigma",  {30'd0, o_sigma}, 32'h3);
    check_eq("n_mosfet", {28'd0, o_MOSFET}, 32'h6);
    check_eq("n_cond",   {28'd0, o_cond}, 32'h3);

    // Enable dropped in N
    i_enable = 1'b0;
    tick(1);
    $display("txn disable: state=%b mosfet=%b", o_state, o_MOSFET);
    check_eq("dis_state",  {30'd0, o_state}, 32'h0);
    check_eq("dis_mosfet", {28'd0, o_MOSFET}, 32'h0);
    check_eq("dis_jump",   {31'd0, o_jump}, 32'h0);
    check_eq("dis_sigma",  {30'd0, o_sigma}, 32'h1);

    // Mode 0: P -> N -> P
    i_mode = 1'b0;
    tick(10);
    check_eq("m0_cond_p", {28'd0, o_cond}, 32'h7);
    i_enable = 1'b1;
    tick(1);
    $display("txn m0 jump: state=%b sigma=%b", o_state, o_sigma);
    check_eq("m0_pn_state", {30'd0, o_state}, 32'h2);
    check_eq("m0_pn_sigma", {30'd0, o_sigma}, 32'h3);
    tick(30);
    check_eq("m0_n_hold", {30'd0, o_state}, 32'h2);
    i_iC = -14'sd1;
    i_ctmf = 16'sd1;
    wait_jump("m0_np_jump", 20);
    check_eq("m0_np_state", {30'd0, o_state}, 32'h0);
    check_eq("m0_np_sigma", {30'd0, o_sigma}, 32'h1);
    tick(30);
    check_eq("m0_p_hold", {30'd0, o_state}, 32'h0);
    check_eq("m0_p_c1",   {31'd0, o_cond[0]}, 32'h0);

    // One-cycle raw C1 glitch must be rejected
    i_iC = '0;
    tick(1);
    i_iC = -14'sd1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      bad = bad | o_cond[0] | o_jump | (o_state != 2'b00);
    end
    $display("txn glitch: bad=%b", bad);
    check_eq("glitch_reject", {31'd0, bad}, 32'h0);

    // Two cycles of raw C1 is enough to jump
    i_iC = '0;
    tick(2);
    i_iC = -14'sd1;
    wait_jump("two_cycle_jump", 20);
    check_eq("two_cycle_state", {30'd0, o_state}, 32'h2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hybrid_control_pipelined.md
# hybrid_control_pipelined

Parametrised, fully synchronous successor of the θ/φ hybrid controller for the resonant converter. It takes scaled vC/iC samples and externally computed sin/cos of (θ+φ) and (θ−φ), then evaluates the three half-plane jump sets in a 3-stage pipeline. Conditions are debounced and blanked, and a clocked 4-state sigma automaton with run-time mode selection steps the state. It sits between the ADC front end / trigonometry blocks and the gate-driver outputs.

## Interface
- W_IN, 14: width of signed i_vC / i_iC
- W_TRIG, 16: width of signed sin/cos inputs
- W_ACC, 64: signed internal accumulator width
- MU_Z1, 86: vC scale
- MU_Z2, 90: iC scale
- MU_VG, 312000: Vg scale
- DEBOUNCE, 2: consecutive true cycles required per condition (≥1)
- MIN_DWELL, 20: cycles jumps are blocked after each jump (values <3 treated as 3)
- DEADTIME, 8: turn-on delay in cycles (only with DEADTIME_EN)
- i_clock  in  1  system clock, all logic on rising edge
- i_RESET  in  1  asynchronous, active-low reset
- i_enable  in  1  1 = run; 0 = outputs safe, state held at P
- i_mode  in  1  1 = four-state phase-shift, 0 = two-state (P↔N)
- i_vC  in  W_IN  signed capacitor voltage
- i_iC  in  W_IN  signed inductor current
- i_stpf, i_ctpf  in  W_TRIG  signed sin/cos(θ+φ)
- i_stmf, i_ctmf  in  W_TRIG  signed sin/cos(θ−φ)
- o_MOSFET  out  4  gate commands
- o_sigma  out  2  signed sigma: +1=01, 0=00, −1=11
- o_state  out  2  automaton state
- o_jump  out  1  one-cycle pulse on each state change
- o_cond  out  4  debounced conditions {C4,C3,C2,C1}

## Operation
- States: P=00 (σ=+1, MOSFET 1001), Z1=01 (σ=0, 0011), N=10 (σ=−1, 0110), Z2=11 (σ=0, 0011).
- Pipeline stage 1 registers:
  - Z1 = MU_Z1·vC − σ·MU_VG
  - Z2 = MU_Z2·iC
  - C = MU_VG·stmf
  - σ is the current registered state.
- Stage 2 registers the products Z1·stmf, Z2·ctmf, Z1·stpf, Z2·ctpf.
- Stage 3 registers:
  - S1 = a+b+C
  - S2 = c+d
  - S3 = a+b−C
- Arithmetic: all operands sign-extended to W_ACC; no saturation; wrap is the user's responsibility.
- Raw conditions:
  - C1 = S1≥0
  - C2 = S2≥0
  - C3 = S3<0
  - C4 = S2<0
- Debounce: each Ck is set after DEBOUNCE consecutive raw-true cycles and cleared on the first raw-false cycle.
- Active condition per state: P→C1, Z1→C2, N→C3, Z2→C4.
- Jump occurs when the active condition is 1, the dwell counter is 0, and i_enable=1.
- Next state:
  - i_mode=1: state+1 mod 4.
  - i_mode=0: from P or Z1 → N; from N or Z2 → P.
- On a jump, the dwell counter loads MIN_DWELL and decrements to 0. This blanks stale pipeline samples.
- i_enable=0: state forced to P, dwell cleared, o_MOSFET=0000, debounce counters keep running.

## Timing
- Reset (async assert, released synchronously to the design):
  - state=P, o_sigma=01, o_state=00, o_MOSFET=0000
  - o_jump=0, o_cond=0000, pipeline and dwell cleared.
- Input sample to raw condition: 3 cycles. Raw to o_cond: DEBOUNCE cycles.
- o_cond high with dwell 0 → state, o_sigma and o_jump update on the next edge.
- o_MOSFET is registered from the state, one cycle after the state.
- i_mode is sampled only at the jump edge; changing it mid-dwell has no effect until the next jump.
- i_enable falling takes effect on the next edge and overrides any simultaneous jump.
- Reset asserted mid-dwell or mid-deadtime aborts the operation immediately to reset values.

## Configuration
- DEADTIME_EN defined:
  - On each o_MOSFET change, bits going 1→0 fall immediately.
  - Bits going 0→1 are held 0 for DEADTIME cycles.
  - A new jump during deadtime restarts the timer against the latest target.
- DEADTIME_EN undefined: o_MOSFET equals the registered decode of the state; DEADTIME is ignored.

## Test plan
- Reset with i_enable=1 and all inputs 0 → o_sigma=01 and o_MOSFET=0000 during reset; o_MOSFET=1001 one cycle after release.
- i_mode=1, stmf=16384, others chosen so S1≥0 → single o_jump pulse; state 00→01; o_sigma=00 after 3+DEBOUNCE+1 cycles; no further jump for MIN_DWELL=20 cycles.
- i_mode=0, conditions forced alternately → state sequence 00→10→00 only; o_sigma 01→11→01.
- Raw C1 true for 1 cycle then false with DEBOUNCE=2 → no jump, o_cond[0] stays 0.
- i_enable dropped while in N → o_MOSFET=0000 next cycle, state=P, o_jump=0.
- DEADTIME_EN, DEADTIME=8, jump P→Z1 → bit3 falls at once; bit1 rises 8 cycles later; bit0 stays 1.
